calc1_port_responder: RTL and testbench

CALC1_PORT_RESPONDER -- requirements
Module: calc1_port_responder

---
 rtl/calc1_port_responder.sv | 146 ++++++++++++++
 tb/tb_calc1_port_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_responder.sv
// calc1_port_responder: two-cycle request port with fixed-latency response.
// Captures a command plus two operands, waits RESP_LAT edges, answers once.
module calc1_port_responder #(
    parameter int unsigned RESP_LAT = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy,
    output logic        out_drop
);

    typedef enum logic [1:0] {
        IDLE,
        OP2,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_LSH  = 4'd5;
    localparam logic [3:0] CMD_RSH  = 4'd6;
    localparam logic [3:0] LAT_INIT = 4'(RESP_LAT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [3:0]  cmd_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;

    logic [32:0] sum;
    logic [4:0]  amt;
    logic [1:0]  res_code;
    logic [31:0] res_data;
    logic        cmd_seen;

    assign cmd_seen = (req_cmd_in != CMD_NOP);
    assign busy     = (state_q != IDLE);

    // State register and latency counter.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: EXEC moves on when the counter is about to reach zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_seen) state_d = OP2;
            end
            OP2: begin
                cnt_d   = LAT_INIT;
                state_d = (LAT_INIT == 4'd0) ? RESP : EXEC;
            end
            EXEC: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Result from captured operands only.
    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, op2_q};
        amt      = op2_q[4:0];
        res_code = 2'd2;
        res_data = 32'd0;
        case (cmd_q)
            CMD_ADD: begin
                if (!sum[32]) begin
                    res_code = 2'd1;
                    res_data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (op2_q <= op1_q) begin
                    res_code = 2'd1;
                    res_data = op1_q - op2_q;
                end
            end
            CMD_LSH: begin
                res_code = 2'd1;
                res_data = op1_q << amt;
            end
            CMD_RSH: begin
                res_code = 2'd1;
                res_data = op1_q >> amt;
            end
            default: begin
                res_code = 2'd2;
                res_data = 32'd0;
            end
        endcase
    end

    // Operand capture, one-cycle response and drop pulse.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cmd_q    <= 4'd0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            out_resp <= 2'd0;
            out_data <= 32'd0;
            out_drop <= 1'b0;
        end else begin
            out_resp <= 2'd0;
            out_data <= 32'd0;
            out_drop <= cmd_seen && (state_q == EXEC || state_q == RESP);
            if (state_q == IDLE && cmd_seen) begin
                cmd_q <= req_cmd_in;
                op1_q <= req_data_in;
            end
            if (state_q == OP2) begin
                op2_q <= req_data_in;
            end
            if (state_q == RESP) begin
                out_resp <= res_code;
                out_data <= res_data;
            end
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// tb_calc1_port_responder: directed and random checks of the responder
// against an arithmetic reference model, cycle-exact on response timing.
module tb_calc1_port_responder;

    localparam int unsigned LAT = 3;

    logic        c_clk;
    logic        reset;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;
    logic        out_drop;

    int n_cmp;
    int n_err;

    calc1_port_responder #(.RESP_LAT(LAT)) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .busy       (busy),
        .out_drop   (out_drop)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on 64-bit integers.
    function automatic void model(input logic [3:0] cmd,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [1:0] r,
                                  output logic [31:0] d);
        longint unsigned wa;
        longint unsigned wb;
        longint unsigned p;
        wa = 64'(a);
        wb = 64'(b);
        p  = 1;
        for (int i = 0; i < int'(wb % 32); i++) p = p * 2;
        r = 2'd2;
        d = 32'd0;
        case (cmd)
            4'd1: if (wa + wb < 64'h1_0000_0000) begin
                r = 2'd1;
                d = 32'(wa + wb);
            end
            4'd2: if (wb <= wa) begin
                r = 2'd1;
                d = 32'(wa - wb);
            end
            4'd5: begin
                r = 2'd1;
                d = 32'((wa * p) % 64'h1_0000_0000);
            end
            4'd6: begin
                r = 2'd1;
                d = 32'(wa / p);
            end
            default: begin
                r = 2'd2;
                d = 32'd0;
            end
        endcase
    endfunction

    // Issue one operation from a negedge; returns at the negedge where
    // the response is visible, so the next call tests earliest acceptance.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [1:0]  er;
        logic [31:0] ed;
        model(cmd, a, b, er, ed);
        req_cmd_in  = cmd;
        req_data_in = a;
        @(negedge c_clk);
        check("busy_after_cmd", 32'(busy), 32'd1);
        check("resp_one_cycle", 32'(out_resp), 32'd0);
        check("data_one_cycle", out_data, 32'd0);
        req_cmd_in  = 4'($urandom_range(0, 15));
        req_data_in = b;
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge c_clk);
            check("resp_early", 32'(out_resp), 32'd0);
            check("drop", 32'(out_drop), (inject && k == 2) ? 32'd1 : 32'd0);
            check("busy_wait", 32'(busy), 32'd1);
            req_cmd_in  = (inject && k == 1) ? 4'd1 : 4'd0;
            req_data_in = $urandom;
        end
        @(negedge c_clk);
        check("resp_code", 32'(out_resp), 32'(er));
        check("resp_data", out_data, ed);
        check("drop_resp", 32'(out_drop), 32'd0);
    endtask

    initial begin
        logic [3:0] c;
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        #3;
        check("rst_resp", 32'(out_resp), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(out_drop), 32'd0);
        @(negedge c_clk);
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(4'd1, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
        run_op(4'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op(4'd2, 32'h80000000, 32'h00000001, 1'b0);
        run_op(4'd2, 32'h00000000, 32'h00000001, 1'b0);
        run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(4'd5, 32'h0F0F0F0F, 32'd4, 1'b0);
        run_op(4'd6, 32'h80000000, 32'd31, 1'b0);
        run_op(4'd5, 32'hFFFFFFFF, 32'd32, 1'b0);
        run_op(4'd6, 32'h12345678, 32'd0, 1'b0);
        run_op(4'd3, 32'h00000005, 32'h00000007, 1'b0);
        run_op(4'd1, 32'h00000010, 32'h00000020, 1'b1);

        // Reset while the response is on the outputs clears it at once.
        req_cmd_in = 4'd0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_resp", 32'(out_resp), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        @(negedge c_clk);
        reset = 1'b1;

        // Reset during EXEC aborts the operation.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd1;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd1;
        @(negedge c_clk);
        check("exec_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_resp", 32'(out_resp), 32'd0);
        @(negedge c_clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge c_clk);
            check("no_resp_after_abort", 32'(out_resp), 32'd0);
            check("idle_after_abort", 32'(busy), 32'd0);
        end
        run_op(4'd1, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: c = 4'd1;
                1: c = 4'd2;
                2: c = 4'd5;
                3: c = 4'd6;
                4: c = 4'($urandom_range(7, 15));
                default: c = 4'($urandom_range(1, 15));
            endcase
            run_op(c, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge c_clk);
        check("final_resp_clear", 32'(out_resp), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
